// File: rtl/bin_to_bcd_converter.sv
// Purpose: sequential double-dabble converter, unsigned binary -> packed BCD,
//          saturating to all-9s when the input exceeds 10^DIGITS-1.
// Latency: accept at edge 0 -> bcd_out/done_out updated at edge IN_WIDTH+1;
//          one conversion per IN_WIDTH+2 cycles.
// Backpressure: ready_out is low while converting; valid_in is ignored then
//          (not queued), bin_in is sampled only at accept.
// Ports:
//   clk_in       rising-edge clock
//   rst_n_in     asynchronous active-low reset
//   bin_in       unsigned value to convert (IN_WIDTH bits)
//   valid_in     bin_in valid; accepted when valid_in && ready_out
//   ready_out    idle, able to accept
//   bcd_out      registered BCD result, digit k in [4k+3:4k]
//   overflow_out last accepted value exceeded 10^DIGITS-1
//   done_out     one-cycle pulse when bcd_out/overflow_out were updated
module bin_to_bcd_converter #(
  parameter int IN_WIDTH = 27,
  parameter int DIGITS   = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [IN_WIDTH-1:0]   bin_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow_out,
  output logic                  done_out
);

  localparam int BW    = 4 * DIGITS;
  localparam int DW    = BW + IN_WIDTH;
  localparam int CNT_W = $clog2(IN_WIDTH + 1);
  // Compare width: 10^DIGITS < 16^DIGITS, so BW bits hold it; +4 gives headroom.
  localparam int CW    = BW + 4;

  function automatic logic [CW-1:0] max_decimal();
    logic [CW-1:0] p;
    p = CW'(1);
    for (int i = 0; i < DIGITS; i++) begin
      p = p * CW'(10);
    end
    return p - CW'(1);
  endfunction

  localparam logic [CW-1:0] MAX_DEC = max_decimal();

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  // {scratch BCD digits, binary shift register} kept as one register so the
  // per-cycle shift moves the binary MSB straight into scratch bit 0.
  logic [DW-1:0]      dd;
  logic [DW-1:0]      dd_adj;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_in) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_W'(IN_WIDTH - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready_out = (state == IDLE);
  end

  // Add-3 correction on every scratch digit >= 5, digits independent.
  always_comb begin
    dd_adj = dd;
    for (int k = 0; k < DIGITS; k++) begin
      if (dd[IN_WIDTH + 4*k +: 4] >= 4'd5) begin
        dd_adj[IN_WIDTH + 4*k +: 4] = dd[IN_WIDTH + 4*k +: 4] + 4'd3;
      end
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dd           <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      bcd_out      <= '0;
      overflow_out <= 1'b0;
      done_out     <= 1'b0;
    end else begin
      done_out <= (state == DONE);
      case (state)
        IDLE: begin
          if (valid_in) begin
            dd  <= {{BW{1'b0}}, bin_in};
            cnt <= '0;
            ovf <= (CW'(bin_in) > MAX_DEC);
          end
        end
        SHIFT: begin
          dd  <= dd_adj << 1;
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          // Saturated display for out-of-range inputs; scratch is garbage then.
          bcd_out      <= ovf ? {DIGITS{4'h9}} : dd[DW-1 -: BW];
          overflow_out <= ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
module tb_bin_to_bcd_converter;

  localparam int IN_WIDTH = 27;
  localparam int DIGITS   = 8;

  logic                clk;
  logic                rst_n;
  logic [IN_WIDTH-1:0] bin_in;
  logic                valid_in;
  logic                ready_out;
  logic [31:0]         bcd_out;
  logic                overflow_out;
  logic                done_out;

  int n_chk  = 0;
  int n_pass = 0;
  int n_acc  = 0;
  int n_done = 0;

  // Reference model state
  int          m_busy  = 0;
  int unsigned m_val   = 0;
  logic [31:0] m_bcd   = '0;
  logic        m_ovf   = 1'b0;
  logic        m_done  = 1'b0;

  bin_to_bcd_converter #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .bin_in       (bin_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .bcd_out      (bcd_out),
    .overflow_out (overflow_out),
    .done_out     (done_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Decimal digits by plain arithmetic, saturating above 99,999,999.
  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    if (v > 32'd99_999_999) return 32'h9999_9999;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Model: an accept makes the result appear IN_WIDTH+1 edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (m_busy > 0) n_acc--;
      m_busy = 0;
      m_bcd  = '0;
      m_ovf  = 1'b0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_bcd  = to_bcd(m_val);
          m_ovf  = (m_val > 32'd99_999_999);
          m_done = 1'b1;
        end
      end else if (valid_in) begin
        m_val  = 32'(bin_in);
        m_busy = IN_WIDTH + 1;
        n_acc++;
      end
    end
  end

  // Every-cycle compare against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_out",    ready_out,    (m_busy == 0));
      chk("done_out",     done_out,     m_done);
      chk("bcd_out",      bcd_out,      m_bcd);
      chk("overflow_out", overflow_out, m_ovf);
      if (done_out) n_done++;
    end
  end

  task automatic wait_done(input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done_out) begin
        got = 1'b1;
        break;
      end
    end
    chk(name, got, 1'b1);
  endtask

  task automatic start(input logic [IN_WIDTH-1:0] v);
    @(negedge clk);
    for (int k = 0; k < 100 && !ready_out; k++) @(negedge clk);
    chk("ready_before_accept", ready_out, 1'b1);
    bin_in   = v;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    bin_in   = IN_WIDTH'($urandom);
  endtask

  task automatic convert(input logic [IN_WIDTH-1:0] v, input string name);
    start(v);
    wait_done(name);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int dcount;
    logic [IN_WIDTH-1:0] v;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    bin_in   = '0;
    #3;
    chk("reset_ready",    ready_out,    1'b1);
    chk("reset_bcd",      bcd_out,      32'h0);
    chk("reset_overflow", overflow_out, 1'b0);
    chk("reset_done",     done_out,     1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Zero input
    convert('0, "done_zero");
    chk("zero_bcd", bcd_out, 32'h0000_0000);
    chk("zero_ovf", overflow_out, 1'b0);
    @(negedge clk);
    chk("zero_done_one_cycle", done_out, 1'b0);

    convert(27'd12_345_678, "done_12345678");
    chk("bcd_12345678", bcd_out, 32'h1234_5678);
    chk("ovf_12345678", overflow_out, 1'b0);

    convert(27'd99_999_999, "done_max");
    chk("bcd_max", bcd_out, 32'h9999_9999);
    chk("ovf_max", overflow_out, 1'b0);
    convert(27'd100_000_000, "done_over");
    chk("bcd_over", bcd_out, 32'h9999_9999);
    chk("ovf_over", overflow_out, 1'b1);
    convert(27'd7, "done_7");
    chk("bcd_7", bcd_out, 32'h0000_0007);
    chk("ovf_7", overflow_out, 1'b0);

    // valid_in held high; bin_in changes mid-conversion
    @(negedge clk);
    bin_in   = 27'd42;
    valid_in = 1'b1;
    repeat (5) @(negedge clk);
    bin_in = 27'd55;
    wait_done("done_42");
    chk("bcd_42", bcd_out, 32'h0000_0042);
    wait_done("done_55");
    valid_in = 1'b0;
    chk("bcd_55", bcd_out, 32'h0000_0055);

    // Reset mid-conversion
    start(27'd87_654_321);
    repeat (9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_bcd",   bcd_out,      32'h0);
    chk("abort_ready", ready_out,    1'b1);
    chk("abort_done",  done_out,     1'b0);
    chk("abort_ovf",   overflow_out, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_out) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    convert(27'd5, "done_5");
    chk("bcd_5", bcd_out, 32'h0000_0005);

    // Randomised sweep, with some values clustered near the saturation point
    for (int i = 0; i < 1000; i++) begin
      if (($urandom % 8) == 0) v = IN_WIDTH'($urandom_range(99_999_999 - 20, 99_999_999 + 20));
      else                     v = IN_WIDTH'($urandom_range(0, (1 << IN_WIDTH) - 1));
      convert(v, "done_random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("done_vs_accept", n_done, n_acc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
